// File: rtl/byte_lane_deserializer_if.sv
// Serial byte stream in, four-lane frame out, for byte_lane_deserializer.
// The slave modport is the deserializer; the master modport is whatever feeds and drains it.
interface byte_lane_deserializer_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_flush;
  logic [DATA_WIDTH-1:0] out_a;
  logic [DATA_WIDTH-1:0] out_b;
  logic [DATA_WIDTH-1:0] out_c;
  logic [DATA_WIDTH-1:0] out_d;
  logic [2:0]            out_count;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output in_data, in_valid, in_flush, out_ready,
    input  in_ready, out_a, out_b, out_c, out_d, out_count, out_valid
  );

  modport slave (
    input  in_data, in_valid, in_flush, out_ready,
    output in_ready, out_a, out_b, out_c, out_d, out_count, out_valid
  );
endinterface

// File: rtl/byte_lane_deserializer.sv
// Packs a valid/ready byte stream into 4-lane frames, with flush-to-pad early close.
// Define BYTE_LANE_DESER_PINGPONG_EN to add a second collection buffer for 1 byte/cycle throughput.
module byte_lane_deserializer #(
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] FILL_VALUE = '0
) (
  input logic                    clk,
  input logic                    rst_n,
  byte_lane_deserializer_if.slave bus
);
  localparam int LANES = 4;
  typedef logic [DATA_WIDTH-1:0] lane_t;

  lane_t      base_lanes    [LANES];
  lane_t      fill_lanes    [LANES];
  lane_t      out_lanes_reg [LANES];
  logic [1:0] idx_reg;
  logic [1:0] idx_step;
  logic [2:0] count_reg;
  logic [2:0] close_count;
  logic       collect_en;
  logic       byte_xfer;
  logic       close;

  assign byte_xfer     = bus.in_valid && bus.in_ready;
  assign bus.out_a     = out_lanes_reg[0];
  assign bus.out_b     = out_lanes_reg[1];
  assign bus.out_c     = out_lanes_reg[2];
  assign bus.out_d     = out_lanes_reg[3];
  assign bus.out_count = count_reg;

  // Frame closes on the 4th byte, or on flush once at least one byte is (or is being) stored.
  always_comb begin
    close       = 1'b0;
    close_count = 3'd4;
    idx_step    = idx_reg;
    if (byte_xfer) begin
      if (idx_reg == 2'd3) begin
        close = 1'b1;
      end else if (bus.in_flush) begin
        close       = 1'b1;
        close_count = {1'b0, idx_reg} + 3'd1;
      end else begin
        idx_step = idx_reg + 2'd1;
      end
    end else if (collect_en && bus.in_flush && idx_reg != 2'd0) begin
      close       = 1'b1;
      close_count = {1'b0, idx_reg};
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_fill
      assign fill_lanes[gi] = (byte_xfer && idx_reg == 2'(gi)) ? bus.in_data :
                              (close && 3'(gi) >= close_count) ? FILL_VALUE :
                              base_lanes[gi];
    end
  endgenerate

`ifdef BYTE_LANE_DESER_PINGPONG_EN
  lane_t      col_lanes_reg [LANES];
  logic [2:0] col_count_reg;
  logic       col_done_reg;
  logic       out_valid_reg;
  logic       out_free;

  assign collect_en    = !col_done_reg;
  assign bus.in_ready  = rst_n && collect_en;
  assign bus.out_valid = out_valid_reg;
  // Output slot is usable this edge if empty or being handed off right now.
  assign out_free      = !out_valid_reg || bus.out_ready;

  generate
    for (gi = 0; gi < LANES; gi++) begin : g_base
      assign base_lanes[gi] = col_lanes_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < LANES; k++) begin
        out_lanes_reg[k] <= '0;
        col_lanes_reg[k] <= '0;
      end
      count_reg     <= '0;
      col_count_reg <= '0;
      idx_reg       <= '0;
      col_done_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      if (out_valid_reg && bus.out_ready) out_valid_reg <= 1'b0;
      if (col_done_reg) begin
        if (out_free) begin
          for (int k = 0; k < LANES; k++) out_lanes_reg[k] <= col_lanes_reg[k];
          count_reg     <= col_count_reg;
          out_valid_reg <= 1'b1;
          col_done_reg  <= 1'b0;
        end
      end else begin
        for (int k = 0; k < LANES; k++) col_lanes_reg[k] <= fill_lanes[k];
        idx_reg <= close ? 2'd0 : idx_step;
        if (close) begin
          // Completed frame bypasses the collection buffer when the output can take it.
          if (out_free) begin
            for (int k = 0; k < LANES; k++) out_lanes_reg[k] <= fill_lanes[k];
            count_reg     <= close_count;
            out_valid_reg <= 1'b1;
          end else begin
            col_count_reg <= close_count;
            col_done_reg  <= 1'b1;
          end
        end
      end
    end
  end
`else
  typedef enum logic {FILL, FULL} state_t;

  state_t     state_reg;
  state_t     state_next;
  lane_t      lanes_next [LANES];
  logic [1:0] idx_next;
  logic [2:0] count_next;

  assign collect_en    = (state_reg == FILL);
  assign bus.in_ready  = rst_n && collect_en;
  assign bus.out_valid = (state_reg == FULL);

  generate
    for (gi = 0; gi < LANES; gi++) begin : g_base
      assign base_lanes[gi] = out_lanes_reg[gi];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    count_next = count_reg;
    for (int k = 0; k < LANES; k++) lanes_next[k] = out_lanes_reg[k];
    case (state_reg)
      FILL: begin
        for (int k = 0; k < LANES; k++) lanes_next[k] = fill_lanes[k];
        idx_next = idx_step;
        if (close) begin
          state_next = FULL;
          idx_next   = 2'd0;
          count_next = close_count;
        end
      end
      FULL: begin
        if (bus.out_ready) state_next = FILL;
      end
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= FILL;
      idx_reg   <= '0;
      count_reg <= '0;
      for (int k = 0; k < LANES; k++) out_lanes_reg[k] <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      count_reg <= count_next;
      for (int k = 0; k < LANES; k++) out_lanes_reg[k] <= lanes_next[k];
    end
  end
`endif
endmodule

// File: doc/byte_lane_deserializer.md
Name: byte_lane_deserializer

Overview:
- Upstream feeder for the four-input byte-lane router.
- Collects a serial valid/ready byte stream into 4-byte frames.
- Presents each frame as four stable parallel lanes (out_a..out_d, feeding router in_a..in_d) with a frame-level valid/ready handshake.
- Supports early frame close (flush) with fill padding, and reports how many lanes carry real data.

Parameters:
- DATA_WIDTH, 8, width of each byte lane and of in_data.
- FILL_VALUE, 8'h00, value written to lanes not filled when a frame is closed early by flush.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_data  input  DATA_WIDTH  serial byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block accepts in_data this cycle.
- in_flush  input  1  close current partial frame; qualified as described below.
- out_a  output  DATA_WIDTH  lane 0 (first accepted byte of frame).
- out_b  output  DATA_WIDTH  lane 1.
- out_c  output  DATA_WIDTH  lane 2.
- out_d  output  DATA_WIDTH  lane 3 (last byte).
- out_count  output  3  number of real bytes in the presented frame, 1..4.
- out_valid  output  1  frame on out_* is valid.
- out_ready  input  1  downstream accepts frame.

Behaviour:
- Reset (rst_n low at a clock edge): out_a..out_d = 0, out_count = 0, out_valid = 0, fill index = 0, state = FILL. in_ready = 0 while rst_n is low.
- Byte transfer occurs on a cycle with in_valid && in_ready. Frame transfer occurs on a cycle with out_valid && out_ready.
- States:
  - FILL: in_ready = 1, out_valid = 0. Each accepted byte is written to the lane at the fill index (0→a … 3→d), then the index increments.
  - FULL: in_ready = 0, out_valid = 1; out_* and out_count are held stable until the frame transfer.
- FILL→FULL at the edge where byte 4 is accepted. out_valid is high on the next cycle (latency 1) with out_count = 4.
- Flush:
  - in_flush is sampled in FILL only.
  - If in_flush is high and a byte transfer occurs on the same cycle, the byte is stored first. The frame then closes with out_count = index+1, and the remaining lanes are set to FILL_VALUE.
  - If in_flush is high with no byte transfer and index > 0, the frame closes with out_count = index.
  - If in_flush is high with index = 0 and no byte transfer, it is ignored; no empty frames are produced.
  - A flush on the cycle byte 4 is accepted is redundant: the result is out_count = 4.
- FULL→FILL at the frame-transfer edge; index resets to 0 and in_ready is high the next cycle. out_* lanes keep their old values until overwritten; consumers must qualify them with out_valid.
- in_flush during FULL is ignored, not queued.
- Back-pressure: with out_ready low, FULL is held indefinitely and no input is accepted.
- A deassertion of rst_n mid-frame discards the partial frame and any held frame without emitting it.
- Flush pad lanes use FILL_VALUE truncated/extended to DATA_WIDTH.

Optional Feature:
- Macro: BYTE_LANE_DESER_PINGPONG_EN.
- Defined:
  - A second collection buffer is added. in_ready stays 1 while the output frame is held, so the next frame fills in parallel.
  - in_ready = 0 only when the collection buffer is complete (or flushed) and the output is still held.
  - A completed collection buffer moves to the output the edge after the output frees, or on the same edge as the frame transfer (zero-bubble).
  - Sustained throughput: 1 byte/cycle with out_ready held high.
  - in_flush applies to the collection buffer in any output state.
- Undefined: single buffer, behaviour exactly as above. Maximum throughput is 4 bytes per 5 cycles with out_ready held high.

Test Plan:
- Full frame: reset, then send 8'h11, 8'h22, 8'h33, 8'h44 on consecutive cycles, out_ready=1 → out_valid high the cycle after 8'h44 is accepted; out_a..d = 11,22,33,44; out_count = 4; in_ready high the following cycle.
- Back-pressure: as above with out_ready=0 for 10 cycles → out_* held stable and in_ready=0 throughout; then out_ready=1 for one cycle → out_valid drops; the next frame is accepted.
- Flush with byte: send 8'hA1, then 8'hA2 with in_flush=1 on the same cycle → out_count=2; lanes A1, A2, 00, 00. Repeat with FILL_VALUE=8'hFF → lanes c, d = FF.
- Flush edge cases: in_flush alone at index 0 → no frame produced. Send 8'h05, then in_flush with no byte → out_count=1, out_a=05. in_flush while FULL → no effect; the next frame is normal.
- Reset mid-operation: send 2 bytes, pull rst_n low for 1 cycle, then send 4 bytes 01..04 → a single frame 01,02,03,04 with out_count=4; no earlier frame is emitted.
- Pingpong (macro defined): stream 12 bytes back-to-back with out_ready=1 → in_ready never drops; three frames on three groups of 4 cycles with no bubble. With out_ready=0, in_ready drops after byte 8.
